// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and Tnew aging helper for the pipeline stage registers
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int TNEW_W_DEF = 3;
    localparam int TNEW_MAX_W = 16;

    function automatic logic [TNEW_MAX_W-1:0] tnew_age(input logic [TNEW_MAX_W-1:0] tnew, input logic dec);
        return (dec && tnew != '0) ? tnew - TNEW_MAX_W'(1) : tnew;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async active-low reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else if (clr) q <= '0;
        else if (inc && !(&q)) q <= q + W'(1);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall, flush, Tnew aging and hazard counters
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int N_DATA        = 3,
    parameter int TNEW_W        = TNEW_W_DEF,
    parameter int TNEW_DEC      = 1,
    parameter int FLUSH_KEEP_PC = 1,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     clr_cnt,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    input  logic                     in_jump,
    input  logic [TNEW_W-1:0]        in_tnew,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic                     out_jump,
    output logic [TNEW_W-1:0]        out_tnew,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    logic              hold;
    logic              bubble;
    logic [TNEW_W-1:0] tnew_aged;

    always_comb begin
        hold      = !flush && !en;
        bubble    = flush || (en && !in_valid);
        tnew_aged = TNEW_W'(tnew_age(TNEW_MAX_W'(in_tnew), TNEW_DEC != 0));
    end

    // A bubble loaded through an invalid slot must not leak a pending Tnew or jump downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            out_jump  <= 1'b0;
            out_tnew  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= (FLUSH_KEEP_PC != 0) ? in_pc : '0;
            out_jump  <= 1'b0;
            out_tnew  <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_instr <= in_instr;
            out_pc    <= in_pc;
            out_jump  <= in_valid && in_jump;
            out_tnew  <= in_valid ? tnew_aged : '0;
            out_data  <= in_data;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (hold),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (bubble),
        .q     (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector bench for pipe_stage_reg, default build (a) and no-dec/no-keep-pc build (b)
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int ND = 3;
    localparam int TW = 3;
    localparam int CW = 4;
    localparam int PW = ND * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_instr = '0;
    logic [31:0]   in_pc = '0;
    logic          in_jump = 1'b0;
    logic [TW-1:0] in_tnew = '0;
    logic [PW-1:0] in_data = '0;

    logic          a_valid, a_jump, b_valid, b_jump;
    logic [31:0]   a_instr, a_pc, b_instr, b_pc;
    logic [TW-1:0] a_tnew, b_tnew;
    logic [PW-1:0] a_data, b_data;
    logic [CW-1:0] a_stall, a_bubble, b_stall, b_bubble;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_reg #(.DATA_W(DW), .N_DATA(ND), .TNEW_W(TW), .TNEW_DEC(1), .FLUSH_KEEP_PC(1), .CNT_W(CW)) dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_jump(in_jump),
        .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc), .out_jump(a_jump),
        .out_tnew(a_tnew), .out_data(a_data), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_stage_reg #(.DATA_W(DW), .N_DATA(ND), .TNEW_W(TW), .TNEW_DEC(0), .FLUSH_KEEP_PC(0), .CNT_W(CW)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_jump(in_jump),
        .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc), .out_jump(b_jump),
        .out_tnew(b_tnew), .out_data(b_data), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, flush, valid, jump;
        logic [31:0]   instr, pc;
        logic [TW-1:0] tnew;
        logic [PW-1:0] data;
        logic          e_valid, e_jump;
        logic [31:0]   e_instr, e_pc_a, e_pc_b;
        logic [TW-1:0] e_tnew_a, e_tnew_b;
        logic [PW-1:0] e_data;
        logic [CW-1:0] e_stall, e_bubble;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic j,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [TW-1:0] t, input logic [PW-1:0] d);
        en = e; flush = f; in_valid = v; in_jump = j;
        in_instr = ins; in_pc = pc; in_tnew = t; in_data = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a_valid"}, 128'(a_valid), 0);
        chk({tag, ".a_instr"}, 128'(a_instr), 0);
        chk({tag, ".a_pc"}, 128'(a_pc), 0);
        chk({tag, ".a_jump"}, 128'(a_jump), 0);
        chk({tag, ".a_tnew"}, 128'(a_tnew), 0);
        chk({tag, ".a_data"}, 128'(a_data), 0);
        chk({tag, ".a_cnt"}, 128'({a_stall, a_bubble}), 0);
        chk({tag, ".b_all"}, 128'({b_valid, b_jump, b_tnew, b_instr, b_pc, b_stall, b_bubble}), 0);
        chk({tag, ".b_data"}, 128'(b_data), 0);
    endtask

    localparam logic [PW-1:0] D1 = {32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    localparam logic [PW-1:0] D2 = {32'hdead_beef, 32'h0000_0000, 32'hffff_ffff};
    localparam logic [PW-1:0] D3 = {32'h0000_0005, 32'h8000_0000, 32'h0000_0008};
    localparam logic [PW-1:0] D4 = {32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff};
    localparam logic [PW-1:0] D5 = {32'h5a5a_5a5a, 32'ha5a5_a5a5, 32'h0000_001f};

    vec_t vecs[11];

    initial begin
        // en flush valid jump instr pc tnew data | valid jump instr pc_a pc_b tnew_a tnew_b data stall bubble
        vecs[0]  = '{1,0,1,1, 32'h2408_0005, 32'h3004, 3, D1,  1,1, 32'h2408_0005, 32'h3004, 32'h3004, 2,3, D1, 0,0};
        vecs[1]  = '{1,0,1,0, 32'h8c01_0000, 32'h3008, 0, D2,  1,0, 32'h8c01_0000, 32'h3008, 32'h3008, 0,0, D2, 0,0};
        vecs[2]  = '{1,0,1,1, 32'h2408_0005, 32'h300c, 3, D3,  1,1, 32'h2408_0005, 32'h300c, 32'h300c, 2,3, D3, 0,0};
        vecs[3]  = '{0,0,1,0, 32'hffff_ffff, 32'h4000, 7, D4,  1,1, 32'h2408_0005, 32'h300c, 32'h300c, 2,3, D3, 1,0};
        vecs[4]  = '{0,0,0,1, 32'h0000_1111, 32'h4004, 1, D5,  1,1, 32'h2408_0005, 32'h300c, 32'h300c, 2,3, D3, 2,0};
        vecs[5]  = '{0,0,1,0, 32'h2222_0000, 32'h4008, 6, D1,  1,1, 32'h2408_0005, 32'h300c, 32'h300c, 2,3, D3, 3,0};
        vecs[6]  = '{0,0,1,1, 32'h3333_0000, 32'h400c, 4, D2,  1,1, 32'h2408_0005, 32'h300c, 32'h300c, 2,3, D3, 4,0};
        vecs[7]  = '{0,1,1,1, 32'hffff_ffff, 32'h3010, 7, D4,  0,0, 32'h0000_0000, 32'h3010, 32'h0000, 0,0, '0, 4,1};
        vecs[8]  = '{1,0,0,1, 32'h1234_5678, 32'h3014, 5, D5,  0,0, 32'h1234_5678, 32'h3014, 32'h3014, 0,0, D5, 4,2};
        vecs[9]  = '{1,1,1,1, 32'h8765_4321, 32'h3018, 6, D1,  0,0, 32'h0000_0000, 32'h3018, 32'h0000, 0,0, '0, 4,3};
        vecs[10] = '{1,0,1,0, 32'habcd_0001, 32'h301c, 1, D1,  1,0, 32'habcd_0001, 32'h301c, 32'h301c, 0,1, D1, 4,3};

        #2;
        chk_all_zero("reset_init");

        reset = 1'b1;
        drive(1, 0, 1, 0, 32'h2408_0001, 32'h3000, 2, D2);
        step();
        chk("rst_rel.a_pc", 128'(a_pc), 128'h3000);
        chk("rst_rel.a_data", 128'(a_data), 128'(D2));
        chk("rst_rel.b_tnew", 128'(b_tnew), 2);
        #2 reset = 1'b0;
        #1 chk_all_zero("reset_mid");
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].en, vecs[i].flush, vecs[i].valid, vecs[i].jump,
                  vecs[i].instr, vecs[i].pc, vecs[i].tnew, vecs[i].data);
            step();
            chk($sformatf("v%0d.valid", i), 128'({a_valid, b_valid}), 128'({2{vecs[i].e_valid}}));
            chk($sformatf("v%0d.jump", i), 128'({a_jump, b_jump}), 128'({2{vecs[i].e_jump}}));
            chk($sformatf("v%0d.instr", i), 128'({a_instr, b_instr}), 128'({2{vecs[i].e_instr}}));
            chk($sformatf("v%0d.a_pc", i), 128'(a_pc), 128'(vecs[i].e_pc_a));
            chk($sformatf("v%0d.b_pc", i), 128'(b_pc), 128'(vecs[i].e_pc_b));
            chk($sformatf("v%0d.a_tnew", i), 128'(a_tnew), 128'(vecs[i].e_tnew_a));
            chk($sformatf("v%0d.b_tnew", i), 128'(b_tnew), 128'(vecs[i].e_tnew_b));
            chk($sformatf("v%0d.a_data", i), 128'(a_data), 128'(vecs[i].e_data));
            chk($sformatf("v%0d.b_data", i), 128'(b_data), 128'(vecs[i].e_data));
            chk($sformatf("v%0d.stall", i), 128'({a_stall, b_stall}), 128'({2{vecs[i].e_stall}}));
            chk($sformatf("v%0d.bubble", i), 128'({a_bubble, b_bubble}), 128'({2{vecs[i].e_bubble}}));
        end

        for (int i = 0; i < 20; i++) begin
            drive(0, 0, i[0], i[1], 32'(i) * 32'h0101_0101, 32'h5000 + 32'(i), TW'(i), {3{32'(i)}});
            step();
            if (i == 10) chk("stall_sat_15", 128'(a_stall), 15);
        end
        chk("stall_sat_a", 128'(a_stall), 15);
        chk("stall_sat_b", 128'(b_stall), 15);
        chk("stall_hold_instr", 128'(a_instr), 128'h abcd_0001);
        chk("stall_hold_tnew", 128'({a_tnew, b_tnew}), 128'({3'd0, 3'd1}));
        chk("stall_hold_data", 128'(a_data), 128'(D1));

        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_stall", 128'({a_stall, b_stall}), 0);
        chk("clr_bubble", 128'({a_bubble, b_bubble}), 0);
        chk("clr_keeps_data", 128'(a_instr), 128'habcd_0001);

        for (int i = 0; i < 17; i++) begin
            drive(i[0], 1, 1, 1, 32'h9999_0000, 32'h6000 + 32'(i), 5, D5);
            step();
        end
        chk("bubble_sat", 128'({a_bubble, b_bubble}), 128'({4'hf, 4'hf}));
        chk("bubble_no_stall", 128'(a_stall), 0);
        chk("flush_pc_last", 128'({a_pc, b_pc}), 128'({32'h6010, 32'h0}));

        drive(0, 1, 1, 1, 32'h9999_0000, 32'h7000, 5, D5);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_over_flush", 128'({a_bubble, a_stall}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
